reset_release_sequencer: RTL

//   Downstream of the global reset generator: takes the synchronous global_resetn and releases
//   NUM_STAGES subsystem resets (PLL domain, memory controller, interconnect, CPUs) in strict order.

---
 rtl/reset_release_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer: releases per-subsystem resets in order, gated on each stage's synchronized ready
module reset_release_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          global_resetn,
  input  logic [NUM_STAGES-1:0]         stage_ready,
  input  logic                          soft_reset_req,
  output logic [NUM_STAGES-1:0]         stage_resetn,
  output logic                          all_released,
  output logic                          timeout_err,
  output logic [$clog2(NUM_STAGES)-1:0] current_stage
);
  localparam int SW = $clog2(NUM_STAGES);
  localparam int M1 = HOLD_CYCLES > SETTLE_CYCLES ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int MX = M1 > TIMEOUT_CYCLES ? M1 : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] HOLD_T = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] SET_T  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_T   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] LAST   = SW'(NUM_STAGES - 1);
  typedef enum logic [2:0] {HOLD, WAIT, SETTLE, DONE, FAULT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_STAGES-1:0] rdy_m, rdy_s, rst_n;
  logic [SW-1:0] cur_n;
  logic rel_n, err_n;
  always_comb begin
    state_n = state;
    cnt_n   = (cnt == '1) ? cnt : cnt + 1'b1;
    rst_n   = stage_resetn;
    rel_n   = all_released;
    err_n   = timeout_err;
    cur_n   = current_stage;
    if (soft_reset_req || (state == DONE && rdy_s != '1)) begin
      state_n = HOLD;
      cnt_n   = '0;
      rst_n   = '0;
      rel_n   = 1'b0;
      cur_n   = '0;
      err_n   = soft_reset_req ? 1'b0 : timeout_err;
    end else begin
      case (state)
        HOLD: if (cnt == HOLD_T) begin
          state_n = WAIT;
          cnt_n   = '0;
          rst_n   = {stage_resetn[NUM_STAGES-2:0], 1'b1};
        end
        WAIT: if (rdy_s[current_stage]) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end else if (cnt == TO_T) begin
          state_n = FAULT;
          rst_n   = '0;
          err_n   = 1'b1;
        end
        SETTLE: if (!rdy_s[current_stage]) begin
          state_n = WAIT;
          cnt_n   = '0;
        end else if (cnt == SET_T) begin
          cnt_n   = '0;
          state_n = (current_stage == LAST) ? DONE : WAIT;
          rel_n   = (current_stage == LAST);
          rst_n   = {stage_resetn[NUM_STAGES-2:0], 1'b1};
          cur_n   = (current_stage == LAST) ? current_stage : current_stage + SW'(1);
        end
        default: ;
      endcase
    end
  end
  // synchronizers are held clear while their stage is in reset, so a stage's ready is only seen after release
  always_ff @(posedge clk) begin
    if (!global_resetn) begin
      state         <= HOLD;
      cnt           <= '0;
      rdy_m         <= '0;
      rdy_s         <= '0;
      stage_resetn  <= '0;
      all_released  <= 1'b0;
      timeout_err   <= 1'b0;
      current_stage <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      rdy_m         <= stage_ready & stage_resetn;
      rdy_s         <= rdy_m & stage_resetn;
      stage_resetn  <= rst_n;
      all_released  <= rel_n;
      timeout_err   <= err_n;
      current_stage <= cur_n;
    end
  end
endmodule
